mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares the single memory_top bus port between N_MASTERS requesters (default 3: instruction fetch, data load/store, DMA).
- Holds one pending request per master, selects a winner, issues it to memory_top as a one-cycle i_bus_DV pulse, waits for memory_top's o_bus_DV, then routes the read data back to the winner.
- Sits between the CPU/DMA ports and memory_top; at most one transaction is outstanding at memory_top at any time.

Parameters:
- N_MASTERS, 3, number of requesters (2..8).
- GRANT_W, 2, width of the grant index; must be at least clog2(N_MASTERS).

Ports:
- i_clk  in  1  system clock, all logic on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req_DV  in  N_MASTERS  one-cycle request pulse per master.
- i_req_address  in  32*N_MASTERS  byte address, master k at [32k+31:32k].
- i_req_data  in  32*N_MASTERS  write data, right-aligned.
- i_req_bhw  in  3*N_MASTERS  access size: 3'b100 word, 3'b010 half, 3'b001 byte.
- i_req_write_notread  in  N_MASTERS  1 = write, 0 = read.
- o_resp_DV  out  N_MASTERS  one-cycle completion pulse to the granted master.
- o_resp_data  out  32  read data, valid while o_resp_DV is nonzero.
- o_overrun  out  1  sticky flag: a master pulsed i_req_DV while its request was still pending.
- o_bus_data / o_bus_address  out  32/32  drive memory_top i_bus_data / i_bus_address.
- o_bus_bhw  out  3  drives memory_top i_bhw.
- o_bus_write_notread  out  1  drives memory_top i_write_notread.
- o_bus_DV  out  1  one-cycle issue pulse to memory_top i_bus_DV.
- i_bus_data  in  32  from memory_top o_bus_data.
- i_bus_DV  in  1  from memory_top o_bus_DV.
- o_grant  out  GRANT_W  index of the current or last granted master.

Behaviour:
- Reset (async assert, sync release): state IDLE; all pending bits 0; o_resp_DV 0; o_resp_data 0; o_bus_DV 0; o_bus_* 0; o_overrun 0; o_grant 0; last_grant = N_MASTERS-1, so master 0 wins first.

Capture:
- i_req_DV[k] while pending[k]=0: latch that master's address, data, bhw and write_notread; set pending[k] on the next edge.
- i_req_DV[k] while pending[k]=1: the pulse is dropped, the stored request is unchanged, o_overrun is set. o_overrun stays set until reset.

FSM IDLE -> ISSUE -> WAIT -> IDLE:
- IDLE, no pending bits: stay in IDLE.
- IDLE, any pending bit: round-robin pick. Search order is last_grant+1 upward, wrapping at N_MASTERS-1 to 0. Register the winner into o_grant.
  - Winner's bhw == 3'b000 or an undefined code: go straight to a response. o_resp_DV[winner]=1 and o_resp_data=0 on the next cycle; clear pending; update last_grant; stay in IDLE. No bus transaction is issued, because memory_top would hang on such a code.
  - Otherwise go to ISSUE.
- ISSUE: o_bus_DV=1 for exactly one cycle. o_bus_address/data/bhw/write_notread carry the winner's fields and hold stable until WAIT exits. Go to WAIT.
- WAIT: on i_bus_DV=1, register i_bus_data into o_resp_data and pulse o_resp_DV[o_grant] on the next cycle. Clear pending[o_grant], set last_grant = o_grant, go to IDLE. No timeout.
- i_bus_DV seen in IDLE or ISSUE (a stale response after reset) is ignored.

Timing:
- Best-case latency: i_req_DV at edge 0, pending at 1, grant at 2, o_bus_DV at 3.
- i_bus_DV to o_resp_DV: 1 cycle.
- Minimum spacing between back-to-back bus issues: 2 cycles after i_bus_DV.

Boundaries:
- A master may issue a new request in the cycle after its own o_resp_DV. It is captured normally, and a pulse that coincides with the pending-clear edge is accepted.
- Simultaneous requests from all masters are served in rotation with no starvation; the worst-case wait is N_MASTERS-1 transactions.
- Reset asserted in WAIT aborts the transaction without a response. memory_top's late o_bus_DV is then ignored.
- Write data is passed right-aligned; memory_top handles byte placement.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN defined: master 0 always wins if pending, and the remaining masters rotate round-robin among themselves. This gives instruction fetch the lowest latency.
- Undefined: pure round-robin across all masters as specified above.

Test Plan:
- Single read: master 1 issues read 0x0000_0100, bhw 100. Expect o_bus_DV one cycle at edge 3 with o_bus_address 0x100. Memory returns 0xCAFE_F00D. Expect o_resp_DV=3'b010 and o_resp_data 0xCAFE_F00D one cycle after i_bus_DV.
- Contention: masters 0, 1 and 2 request in the same cycle. Expect bus issues in order 0, 1, 2. A second round issued immediately after must again grant 0, 1, 2, with one o_resp_DV per master.
- Overrun: master 2 pulses twice, 1 cycle apart. Expect only the first request issued with the first request's address, and o_overrun=1 held until reset.
- Invalid size: master 0 requests with bhw 000. Expect no o_bus_DV, o_resp_DV[0] within 2 cycles, and o_resp_data 0.
- Reset mid-WAIT: drop i_rst_n during WAIT, then release. Inject i_bus_DV. Expect no o_resp_DV, all outputs 0, and the next request granting master 0.
- MEM_ARB_FIXED_PRIO_EN: masters 1 and 2 pending and master 0 requests continuously. Expect master 0 granted after every transaction, with masters 1 and 2 alternating between them.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the single memory_top bus port between N_MASTERS requesters
// (instruction fetch, data load/store, DMA). Each master has one request slot.
// The arbiter picks a winner and issues it to memory_top as a one-cycle
// o_bus_DV pulse. It then waits for memory_top's i_bus_DV and routes the read
// data back to the winner. At most one transaction is outstanding at memory_top.
//
// Optional build macro:
//   MEM_ARB_FIXED_PRIO_EN  - master 0 always wins when pending; the remaining
//                            masters rotate round-robin among themselves.
//                            Undefined: pure round-robin across all masters.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_req_DV[N]               one-cycle request pulse per master
//   i_req_address[32N]        byte address, master k at [32k+31:32k]
//   i_req_data[32N]           right-aligned write data
//   i_req_bhw[3N]             size: 100 word, 010 half, 001 byte
//   i_req_write_notread[N]    1 = write, 0 = read
//   o_resp_DV[N]              one-cycle completion pulse to the served master
//   o_resp_data[32]           read data, valid while o_resp_DV is nonzero
//   o_overrun                 sticky: request pulse seen while still pending
//   o_bus_*                   request fields and issue pulse to memory_top
//   i_bus_data, i_bus_DV      response from memory_top
//   o_grant[GRANT_W]          index of the current or last granted master
// ----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int N_MASTERS = 3,
  parameter int GRANT_W   = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [N_MASTERS-1:0]     i_req_DV,
  input  logic [32*N_MASTERS-1:0]  i_req_address,
  input  logic [32*N_MASTERS-1:0]  i_req_data,
  input  logic [3*N_MASTERS-1:0]   i_req_bhw,
  input  logic [N_MASTERS-1:0]     i_req_write_notread,
  output logic [N_MASTERS-1:0]     o_resp_DV,
  output logic [31:0]              o_resp_data,
  output logic                     o_overrun,
  output logic [31:0]              o_bus_data,
  output logic [31:0]              o_bus_address,
  output logic [2:0]               o_bus_bhw,
  output logic                     o_bus_write_notread,
  output logic                     o_bus_DV,
  input  logic [31:0]              i_bus_data,
  input  logic                     i_bus_DV,
  output logic [GRANT_W-1:0]       o_grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [N_MASTERS-1:0]    pending_q;
  logic [N_MASTERS-1:0]    accept;
  logic [N_MASTERS-1:0]    clr;
  logic [32*N_MASTERS-1:0] addr_q;
  logic [32*N_MASTERS-1:0] data_q;
  logic [3*N_MASTERS-1:0]  bhw_q;
  logic [N_MASTERS-1:0]    wn_q;
  logic [GRANT_W-1:0]      last_grant_q;
  logic [GRANT_W-1:0]      win;

  logic        do_grant, do_short, do_issue, do_done;
  logic [31:0] sel_addr, sel_data;
  logic [2:0]  sel_bhw, win_bhw;
  logic        sel_wn;

  // Only the three one-hot size codes are legal; anything else would hang
  // memory_top, so such requests are answered locally.
  function automatic logic valid_bhw(input logic [2:0] b);
    return (b == 3'b100) || (b == 3'b010) || (b == 3'b001);
  endfunction

  // First pending master strictly after 'last', wrapping at N_MASTERS-1.
  function automatic logic [GRANT_W-1:0] rr_pick(input logic [N_MASTERS-1:0] pend,
                                                 input logic [GRANT_W-1:0]   last);
    logic [GRANT_W-1:0] pick;
    logic               found;
    int                 idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      idx = (int'(last) + i) % N_MASTERS;
      if (!found && (((pend >> idx) & N_MASTERS'(1)) != '0)) begin
        pick  = GRANT_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Master 0 pre-empts the rotation; the pointer only tracks masters 1..N-1.
  function automatic logic [GRANT_W-1:0] arb_pick(input logic [N_MASTERS-1:0] pend,
                                                  input logic [GRANT_W-1:0]   last);
    if (pend[0]) return '0;
    return rr_pick(pend & ~N_MASTERS'(1), last);
  endfunction

  function automatic logic [GRANT_W-1:0] next_last(input logic [GRANT_W-1:0] cur,
                                                   input logic [GRANT_W-1:0] w);
    return (w == '0) ? cur : w;
  endfunction
`else
  function automatic logic [GRANT_W-1:0] arb_pick(input logic [N_MASTERS-1:0] pend,
                                                  input logic [GRANT_W-1:0]   last);
    return rr_pick(pend, last);
  endfunction

  function automatic logic [GRANT_W-1:0] next_last(input logic [GRANT_W-1:0] cur,
                                                   input logic [GRANT_W-1:0] w);
    return (cur == w) ? cur : w;
  endfunction
`endif

  assign win = arb_pick(pending_q, last_grant_q);

  // Field muxes: granted master for the bus, arbitration winner for the size check.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_bhw  = '0;
    sel_wn   = 1'b0;
    win_bhw  = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (o_grant == GRANT_W'(k)) begin
        sel_addr = addr_q[32*k +: 32];
        sel_data = data_q[32*k +: 32];
        sel_bhw  = bhw_q[3*k +: 3];
        sel_wn   = wn_q[k];
      end
      if (win == GRANT_W'(k)) win_bhw = bhw_q[3*k +: 3];
    end
  end

  always_comb begin
    state_d  = state_q;
    do_grant = 1'b0;
    do_short = 1'b0;
    do_issue = 1'b0;
    do_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|pending_q) begin
          do_grant = 1'b1;
          if (valid_bhw(win_bhw)) state_d  = ISSUE;
          else                    do_short = 1'b1;
        end
      end
      ISSUE: begin
        do_issue = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (i_bus_DV) begin
          do_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending slot being released this edge; a new pulse on that same edge is
  // a fresh request, not an overrun.
  always_comb begin
    clr = '0;
    if (do_short)     clr = N_MASTERS'(1) << win;
    else if (do_done) clr = N_MASTERS'(1) << o_grant;
  end

  assign accept = i_req_DV & (~pending_q | clr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Request capture stage: per-master field storage.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < N_MASTERS; k++) begin
      if (accept[k]) begin
        addr_q[32*k +: 32] <= i_req_address[32*k +: 32];
        data_q[32*k +: 32] <= i_req_data[32*k +: 32];
        bhw_q[3*k +: 3]    <= i_req_bhw[3*k +: 3];
        wn_q[k]            <= i_req_write_notread[k];
      end
    end
  end

  // Control, bus-issue and response stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending_q           <= '0;
      o_overrun           <= 1'b0;
      o_grant             <= '0;
      last_grant_q        <= GRANT_W'(N_MASTERS - 1);
      o_resp_DV           <= '0;
      o_resp_data         <= '0;
      o_bus_DV            <= 1'b0;
      o_bus_address       <= '0;
      o_bus_data          <= '0;
      o_bus_bhw           <= '0;
      o_bus_write_notread <= 1'b0;
    end else begin
      pending_q <= (pending_q & ~clr) | accept;
      if (|(i_req_DV & pending_q & ~clr)) o_overrun <= 1'b1;
      o_resp_DV <= clr;
      o_bus_DV  <= do_issue;
      if (do_grant) o_grant <= win;
      if (do_issue) begin
        o_bus_address       <= sel_addr;
        o_bus_data          <= sel_data;
        o_bus_bhw           <= sel_bhw;
        o_bus_write_notread <= sel_wn;
      end
      if (do_done) begin
        o_resp_data  <= i_bus_data;
        last_grant_q <= next_last(last_grant_q, o_grant);
      end else if (do_short) begin
        o_resp_data  <= '0;
        last_grant_q <= next_last(last_grant_q, win);
      end
    end
  end

endmodule
